// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder and its storage array.
// Widths and parameter defaults live here so the top, the array and the interface agree on them.
package corg_mem_pkg;

    localparam int ADDR_W          = 8;
    localparam int DATA_W          = 8;
    localparam int DEPTH_DEF       = 256;
    localparam int WAIT_CYCLES_DEF = 2;
    // Wide enough for the full 0..15 wait range
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response and preload signals between a control unit and the memory responder.
// The master modport is the requester side; the slave modport is the responder side.
interface mem_responder_if;
    import corg_mem_pkg::*;

    logic              mem_cs;
    logic              mem_wr;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] memout;
    logic              mem_ready;
    logic              busy;
    logic              load_ack;

    modport master (
        output mem_cs, mem_wr, address, data, load_en, load_addr, load_data,
        input  memout, mem_ready, busy, load_ack
    );

    modport slave (
        input  mem_cs, mem_wr, address, data, load_en, load_addr, load_data,
        output memout, mem_ready, busy, load_ack
    );

endinterface

// File: rtl/mem_responder_mem_array.sv
// Single-write-port storage with synchronous write and registered read.
// Has no reset, so its contents survive a responder reset; out-of-range writes are dropped and out-of-range reads return zero.
module mem_array_256x8
    import corg_mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              wr_ok;
    logic              rd_ok;

    assign wr_idx = wr_addr[IDX_W-1:0];
    assign rd_idx = rd_addr[IDX_W-1:0];
    // Range check on the full address so no out-of-range access aliases onto a low word
    assign wr_ok  = ({1'b0, wr_addr} < DEPTH_L);
    assign rd_ok  = ({1'b0, rd_addr} < DEPTH_L);

    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) begin
            mem[wr_idx] <= wr_data;
        end
        rd_data_reg <= rd_ok ? mem[rd_idx] : '0;
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one chip-select request at a time, inserts WAIT_CYCLES wait states, then completes with a one-cycle ready pulse.
// A preload port writes storage directly while idle, and a new request takes priority over a preload in the same cycle.
module mem_responder
    import corg_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int DEPTH       = DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              wr_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] data_reg;
    logic [DATA_W-1:0] memout_reg;
    logic              ready_reg;
    logic              load_ack_reg;

    logic              accept;
    logic              preload;
    logic              finish;
    logic              arr_wr_en;
    logic [ADDR_W-1:0] arr_wr_addr;
    logic [DATA_W-1:0] arr_wr_data;
    logic [ADDR_W-1:0] arr_rd_addr;
    logic [DATA_W-1:0] arr_rd_data;

    assign accept  = (state_reg == IDLE) && !bus.mem_cs;
    assign preload = (state_reg == IDLE) &&  bus.mem_cs && bus.load_en;
    assign finish  = (state_reg == BUSY) && (cnt_reg == '0);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = BUSY;
                    cnt_next   = WAIT_INIT;
                end
            end
            BUSY: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Preloads and transaction writes never coincide: preloads happen only in IDLE, writes only on leaving BUSY
    assign arr_wr_en   = preload || (finish && wr_reg);
    assign arr_wr_addr = preload ? bus.load_addr : addr_reg;
    assign arr_wr_data = preload ? bus.load_data : data_reg;

    // Read the incoming address while idle so the word is ready even with zero wait states
    assign arr_rd_addr = (state_reg == IDLE) ? bus.address : addr_reg;

    mem_array_256x8 #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (arr_wr_en),
        .wr_addr (arr_wr_addr),
        .wr_data (arr_wr_data),
        .rd_addr (arr_rd_addr),
        .rd_data (arr_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            wr_reg       <= 1'b0;
            addr_reg     <= '0;
            data_reg     <= '0;
            memout_reg   <= '0;
            ready_reg    <= 1'b0;
            load_ack_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            ready_reg    <= (state_next == DONE);
            load_ack_reg <= preload;
            if (accept) begin
                wr_reg   <= bus.mem_wr;
                addr_reg <= bus.address;
                data_reg <= bus.data;
            end
            if (finish && !wr_reg) begin
                memout_reg <= arr_rd_data;
            end
        end
    end

    assign bus.memout    = memout_reg;
    assign bus.mem_ready = ready_reg;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.load_ack  = load_ack_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: instance A uses WAIT_CYCLES=2 with DEPTH=256, instance B uses WAIT_CYCLES=0 with DEPTH=64.
// Inputs change 1 time unit after a rising edge, and outputs are checked at that same point.
module tb_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_bad    = 0;

    always #5 clk = ~clk;

    mem_responder_if bus_a ();
    mem_responder_if bus_b ();

    mem_responder #(.WAIT_CYCLES(2), .DEPTH(256)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    mem_responder #(.WAIT_CYCLES(0), .DEPTH(64))  u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int w, input logic cs, input logic wr, input logic [7:0] a, input logic [7:0] d);
        if (w == 0) begin
            bus_a.mem_cs = cs; bus_a.mem_wr = wr; bus_a.address = a; bus_a.data = d;
        end else begin
            bus_b.mem_cs = cs; bus_b.mem_wr = wr; bus_b.address = a; bus_b.data = d;
        end
    endtask

    task automatic drive_load(input int w, input logic en, input logic [7:0] a, input logic [7:0] d);
        if (w == 0) begin
            bus_a.load_en = en; bus_a.load_addr = a; bus_a.load_data = d;
        end else begin
            bus_b.load_en = en; bus_b.load_addr = a; bus_b.load_data = d;
        end
    endtask

    function automatic logic [7:0] get_memout(input int w);
        return (w == 0) ? bus_a.memout : bus_b.memout;
    endfunction

    function automatic logic get_ready(input int w);
        return (w == 0) ? bus_a.mem_ready : bus_b.mem_ready;
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 0) ? bus_a.busy : bus_b.busy;
    endfunction

    function automatic logic get_ack(input int w);
        return (w == 0) ? bus_a.load_ack : bus_b.load_ack;
    endfunction

    // Waits (bounded) for the ready pulse; k_start is the number of edges already seen since accept
    task automatic finish_txn(input int w, input int k_start, input int exp_lat, input string tag);
        int k;
        k = k_start;
        while (!get_ready(w) && k < 40) begin
            tick;
            k++;
        end
        check_eq({tag, "_lat"}, k, exp_lat);
        tick;
    endtask

    task automatic txn(input int w, input logic wr, input logic [7:0] a, input logic [7:0] d,
                       input int exp_lat, input string tag);
        drive(w, 1'b0, wr, a, d);
        tick;
        drive(w, 1'b1, wr, a, d);
        check_eq({tag, "_busy"}, get_busy(w), 1'b1);
        finish_txn(w, 0, exp_lat, tag);
    endtask

    task automatic preload(input int w, input logic [7:0] a, input logic [7:0] d, input string tag);
        drive_load(w, 1'b1, a, d);
        tick;
        drive_load(w, 1'b0, a, d);
        check_eq({tag, "_ack1"}, get_ack(w), 1'b1);
        tick;
        check_eq({tag, "_ack0"}, get_ack(w), 1'b0);
    endtask

    initial begin
        int first_rdy;
        int second_rdy;
        int idle_gap;

        drive(0, 1'b1, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b1, 1'b0, 8'h00, 8'h00);
        drive_load(0, 1'b0, 8'h00, 8'h00);
        drive_load(1, 1'b0, 8'h00, 8'h00);
        #2;
        check_eq("rst_memout_a", bus_a.memout, 8'h00);
        check_eq("rst_ready_a", bus_a.mem_ready, 1'b0);
        check_eq("rst_busy_a", bus_a.busy, 1'b0);
        check_eq("rst_ack_a", bus_a.load_ack, 1'b0);
        check_eq("rst_memout_b", bus_b.memout, 8'h00);
        repeat (3) tick;
        rst = 1'b0;
        tick;

        // Preload then read with two wait states
        preload(0, 8'h10, 8'h3C, "pl10");
        txn(0, 1'b0, 8'h10, 8'h00, 3, "rd10");
        check_eq("rd10_memout", get_memout(0), 8'h3C);
        check_eq("rd10_ready_gone", get_ready(0), 1'b0);

        // Zero wait states: writes leave memout alone
        txn(1, 1'b1, 8'h20, 8'hA5, 1, "b_wr20");
        check_eq("b_wr20_memout", get_memout(1), 8'h00);
        txn(1, 1'b0, 8'h20, 8'h00, 1, "b_rd20");
        check_eq("b_rd20_memout", get_memout(1), 8'hA5);
        txn(1, 1'b1, 8'h20, 8'h5A, 1, "b_wr20b");
        check_eq("b_wr20b_memout", get_memout(1), 8'hA5);
        txn(1, 1'b0, 8'h20, 8'h00, 1, "b_rd20b");
        check_eq("b_rd20b_memout", get_memout(1), 8'h5A);

        // Out-of-range on the 64-word instance: write dropped without aliasing, read returns zero
        preload(1, 8'h00, 8'h66, "b_pl00");
        txn(1, 1'b1, 8'h80, 8'hAB, 1, "b_wr80");
        txn(1, 1'b0, 8'h80, 8'h00, 1, "b_rd80");
        check_eq("b_rd80_memout", get_memout(1), 8'h00);
        txn(1, 1'b0, 8'h00, 8'h00, 1, "b_rd00");
        check_eq("b_rd00_memout", get_memout(1), 8'h66);

        // Chip select held low: period is accept + 2 waits + DONE + one IDLE = 5 edges
        first_rdy  = -1;
        second_rdy = -1;
        idle_gap   = 0;
        drive(0, 1'b0, 1'b0, 8'h10, 8'h00);
        for (int i = 1; i <= 16; i++) begin
            tick;
            if (get_ready(0)) begin
                if (first_rdy < 0) first_rdy = i;
                else if (second_rdy < 0) second_rdy = i;
            end
            if (first_rdy >= 0 && second_rdy < 0 && !get_busy(0)) idle_gap++;
        end
        drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
        repeat (6) tick;
        check_eq("hold_first_rdy", first_rdy, 4);
        check_eq("hold_period", second_rdy - first_rdy, 5);
        check_eq("hold_idle_gap", idle_gap, 1);
        check_eq("hold_end_busy", get_busy(0), 1'b0);

        // Request beats a same-cycle preload
        preload(0, 8'h30, 8'h11, "pl30");
        preload(0, 8'h31, 8'h22, "pl31");
        drive_load(0, 1'b1, 8'h30, 8'h99);
        drive(0, 1'b0, 1'b0, 8'h30, 8'h00);
        tick;
        drive_load(0, 1'b0, 8'h30, 8'h99);
        drive(0, 1'b1, 1'b0, 8'h30, 8'h00);
        check_eq("race_ack", get_ack(0), 1'b0);
        check_eq("race_busy", get_busy(0), 1'b1);
        finish_txn(0, 0, 3, "race");
        check_eq("race_memout", get_memout(0), 8'h11);

        // Preload while busy is ignored
        drive(0, 1'b0, 1'b0, 8'h10, 8'h00);
        tick;
        drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
        drive_load(0, 1'b1, 8'h31, 8'h44);
        tick;
        check_eq("busyload_ack", get_ack(0), 1'b0);
        drive_load(0, 1'b0, 8'h31, 8'h44);
        finish_txn(0, 1, 3, "busyload");
        check_eq("busyload_ack_after", get_ack(0), 1'b0);
        txn(0, 1'b0, 8'h31, 8'h00, 3, "rd31");
        check_eq("rd31_memout", get_memout(0), 8'h22);

        // Inputs changed mid-transaction must not matter
        preload(0, 8'h41, 8'h33, "pl41");
        drive(0, 1'b0, 1'b1, 8'h40, 8'h12);
        tick;
        drive(0, 1'b1, 1'b0, 8'h41, 8'hEE);
        finish_txn(0, 0, 3, "midwr");
        drive(0, 1'b0, 1'b0, 8'h10, 8'h00);
        tick;
        drive(0, 1'b1, 1'b1, 8'h40, 8'hFF);
        finish_txn(0, 0, 3, "midrd");
        check_eq("midrd_memout", get_memout(0), 8'h3C);
        txn(0, 1'b0, 8'h40, 8'h00, 3, "rd40");
        check_eq("rd40_memout", get_memout(0), 8'h12);
        txn(0, 1'b0, 8'h41, 8'h00, 3, "rd41");
        check_eq("rd41_memout", get_memout(0), 8'h33);

        // Reset during BUSY aborts the write; outputs clear before any clock edge
        preload(0, 8'h05, 8'h5E, "pl05");
        drive(0, 1'b0, 1'b1, 8'h05, 8'h77);
        tick;
        drive(0, 1'b1, 1'b1, 8'h05, 8'h77);
        tick;
        check_eq("abort_pre_busy", get_busy(0), 1'b1);
        check_eq("abort_pre_memout", get_memout(0), 8'h33);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_busy", get_busy(0), 1'b0);
        check_eq("abort_ready", get_ready(0), 1'b0);
        check_eq("abort_memout", get_memout(0), 8'h00);
        tick;
        check_eq("abort_ready_hold", get_ready(0), 1'b0);
        rst = 1'b0;
        tick;
        check_eq("abort_ready_post", get_ready(0), 1'b0);
        tick;
        check_eq("abort_ready_post2", get_ready(0), 1'b0);
        check_eq("abort_busy_post", get_busy(0), 1'b0);
        txn(0, 1'b0, 8'h05, 8'h00, 3, "rd05");
        check_eq("rd05_memout", get_memout(0), 8'h5E);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
